// File: rtl/ppu_mode_if.sv
// ppu_mode_if: control inputs and timing outputs of the PPU mode sequencer
interface ppu_mode_if #(
  parameter int LY_W  = 8,
  parameter int DOT_W = 9
);
  logic             lcd_en;
  logic [LY_W-1:0]  lyc;
  logic [3:0]       stat_sel;
  logic             mode3_done;
  logic             mode2_start;
  logic             mode3_start;
  logic [1:0]       mode;
  logic [LY_W-1:0]  ly;
  logic [DOT_W-1:0] dot;
  logic             lyc_match;
  logic             stat_irq;
  logic             vblank_irq;
  logic             frame_start;
  logic             mode3_timeout;
  modport master (
    output lcd_en, lyc, stat_sel, mode3_done,
    input  mode2_start, mode3_start, mode, ly, dot, lyc_match,
           stat_irq, vblank_irq, frame_start, mode3_timeout
  );
  modport slave (
    input  lcd_en, lyc, stat_sel, mode3_done,
    output mode2_start, mode3_start, mode, ly, dot, lyc_match,
           stat_irq, vblank_irq, frame_start, mode3_timeout
  );
endinterface

// File: rtl/ppu_mode_sequencer.sv
// ppu_mode_sequencer: scanline/frame timing, PPU mode FSM and STAT/vblank interrupts
module ppu_mode_sequencer #(
  parameter int LINE_CYCLES   = 456,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154,
  parameter int OAM_CYCLES    = 80,
  parameter int MODE3_MAX     = 289,
  parameter int LY_W          = 8,
  parameter int DOT_W         = 9
) (
  input logic       clk,
  input logic       rst,
  ppu_mode_if.slave bus
);
  typedef enum logic [2:0] {OFF, OAM, XFER, HBLANK, VBLANK} state_t;
  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(LINE_CYCLES - 1);
  localparam logic [DOT_W-1:0] XFER_DOT  = DOT_W'(OAM_CYCLES);
  localparam logic [DOT_W-1:0] XFER_LAST = DOT_W'(OAM_CYCLES + MODE3_MAX - 1);
  localparam logic [LY_W-1:0]  LY_LAST   = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]  LY_VBL    = LY_W'(VISIBLE_LINES);
  state_t           st;
  logic [LY_W-1:0]  ly, ly_n;
  logic [DOT_W-1:0] dot, dot_n;
  logic             dot_wrap, lyc_match, stat_line, stat_prev;
  logic             m2s, m3s, vbi, fs, sirq, tmo;
  always_comb begin
    dot_wrap = dot == DOT_LAST;
    dot_n    = dot_wrap ? '0 : dot + DOT_W'(1);
    ly_n     = dot_wrap ? (ly == LY_LAST ? '0 : ly + LY_W'(1)) : ly;
  end
  assign lyc_match = ly == bus.lyc;
  assign stat_line = (lyc_match & bus.stat_sel[3]) | ((st == OAM) & bus.stat_sel[2]) |
                     ((st == VBLANK) & bus.stat_sel[1]) | ((st == HBLANK) & bus.stat_sel[0]);
  always_ff @(posedge clk) begin
    if (rst || !bus.lcd_en) begin
      st        <= OFF;
      ly        <= '0;
      dot       <= '0;
      m2s       <= 1'b0;
      m3s       <= 1'b0;
      vbi       <= 1'b0;
      fs        <= 1'b0;
      sirq      <= 1'b0;
      stat_prev <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      m2s       <= 1'b0;
      m3s       <= 1'b0;
      vbi       <= 1'b0;
      fs        <= 1'b0;
      // OFF contributes no STAT history, so the first enabled cycle can raise an edge
      stat_prev <= (st != OFF) && stat_line;
      sirq      <= (st != OFF) && stat_line && !stat_prev;
      if (st == OFF) begin
        st  <= OAM;
        ly  <= '0;
        dot <= '0;
        m2s <= 1'b1;
        fs  <= 1'b1;
      end else begin
        dot <= dot_n;
        ly  <= ly_n;
        if (dot_wrap) begin
          if (ly_n < LY_VBL) begin
            st  <= OAM;
            m2s <= 1'b1;
            fs  <= ly_n == '0;
          end else begin
            st  <= VBLANK;
            vbi <= ly_n == LY_VBL;
          end
        end else if (st == OAM && dot_n == XFER_DOT) begin
          st  <= XFER;
          m3s <= 1'b1;
        end else if (st == XFER && (bus.mode3_done || dot == XFER_LAST)) begin
          st <= HBLANK;
          if (!bus.mode3_done) tmo <= 1'b1;
        end
      end
    end
  end
  assign bus.mode          = st == OAM ? 2'd2 : st == XFER ? 2'd3 : st == VBLANK ? 2'd1 : 2'd0;
  assign bus.ly            = ly;
  assign bus.dot           = dot;
  assign bus.lyc_match     = lyc_match;
  assign bus.mode2_start   = m2s;
  assign bus.mode3_start   = m3s;
  assign bus.vblank_irq    = vbi;
  assign bus.frame_start   = fs;
  assign bus.stat_irq      = sirq;
  assign bus.mode3_timeout = tmo;
endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb_ppu_mode_sequencer: directed checks of line/frame timing, mode 3 timeout, STAT blocking, LCD off and reset
module tb_ppu_mode_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  always #5 clk = ~clk;
  ppu_mode_if if1 ();
  ppu_mode_if if2 ();
  ppu_mode_sequencer u1 (.clk(clk), .rst(rst), .bus(if1));
  ppu_mode_sequencer #(
    .LINE_CYCLES(220), .VISIBLE_LINES(70), .TOTAL_LINES(80), .OAM_CYCLES(20), .MODE3_MAX(60)
  ) u2 (.clk(clk), .rst(rst), .bus(if2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    int le, de, em;
    int bad_pos, bad_str, bad_stat, bad_to, vb_cnt, fs_cnt;
    bad_pos = 0; bad_str = 0; bad_stat = 0; bad_to = 0; vb_cnt = 0; fs_cnt = 0;
    rst = 1'b1;
    if1.lcd_en = 1'b1; if1.lyc = 8'd5; if1.stat_sel = 4'b1000; if1.mode3_done = 1'b0;
    if2.lcd_en = 1'b0; if2.lyc = 8'd0; if2.stat_sel = 4'b0000; if2.mode3_done = 1'b0;
    tick; tick;
    chk("rst_mode", if1.mode, 0);
    chk("rst_ly", if1.ly, 0);
    chk("rst_dot", if1.dot, 0);
    chk("rst_strobes", {if1.mode2_start, if1.mode3_start, if1.frame_start}, 0);
    chk("rst_irqs", {if1.vblank_irq, if1.stat_irq}, 0);
    chk("rst_timeout", if1.mode3_timeout, 0);
    chk("rst_lyc_nomatch", if1.lyc_match, 0);
    if1.lyc = 8'd0; #1;
    chk("lyc_immediate", if1.lyc_match, 1);
    if1.lyc = 8'd5; #1;
    chk("lyc_restore", if1.lyc_match, 0);
    rst = 1'b0;
    tick;
    for (int c = 0; c < 70224; c++) begin
      le = c / 456;
      de = c % 456;
      em = le >= 144 ? 1 : de < 80 ? 2 : de < (le == 0 ? 253 : 369) ? 3 : 0;
      bad_pos  += int'(if1.ly !== 8'(le) || if1.dot !== 9'(de) || if1.mode !== 2'(em));
      bad_str  += int'(if1.mode2_start !== (le < 144 && de == 0)) + int'(if1.mode3_start !== (le < 144 && de == 80))
                + int'(if1.frame_start !== (c == 0)) + int'(if1.vblank_irq !== (c == 65664));
      bad_stat += int'(if1.stat_irq !== (c == 2281)) + int'(if1.lyc_match !== (le == 5));
      bad_to   += int'(if1.mode3_timeout !== (c >= 825));
      vb_cnt   += int'(if1.vblank_irq);
      fs_cnt   += int'(if1.frame_start);
      if (c == 0) chk("first_oam", {if1.mode, if1.mode2_start, if1.frame_start}, {2'd2, 1'b1, 1'b1});
      if (c == 79) chk("oam_last", if1.mode, 2);
      if (c == 80) chk("xfer_first", {if1.mode, if1.mode3_start}, {2'd3, 1'b1});
      if (c == 252) chk("xfer_last", if1.mode, 3);
      if (c == 253) chk("hblank_first", {if1.mode, if1.mode3_timeout}, {2'd0, 1'b0});
      if (c == 455) chk("line0_end", {if1.ly, 7'd0, if1.dot}, {8'd0, 7'd0, 9'd455});
      if (c == 456) chk("line1_start", {if1.ly, if1.dot, if1.mode2_start, if1.frame_start}, {8'd1, 9'd0, 1'b1, 1'b0});
      if (c == 824) chk("to_xfer_last", {if1.mode, if1.mode3_timeout}, {2'd3, 1'b0});
      if (c == 825) chk("to_hblank", {if1.mode, if1.mode3_timeout}, {2'd0, 1'b1});
      if (c == 912) chk("to_line_len", {if1.ly, if1.dot, if1.mode}, {8'd2, 9'd0, 2'd2});
      if (c == 953) chk("done_in_oam", if1.mode, 2);
      if (c == 1769) chk("done_in_hblank", if1.mode, 0);
      if (c == 2281) chk("stat_lyc_pulse", if1.stat_irq, 1);
      if (c == 2649) chk("hblank_lyc_high", {if1.mode, if1.lyc_match}, {2'd0, 1'b1});
      if (c == 2650) chk("stat_blocked", if1.stat_irq, 0);
      if (c == 65663) chk("pre_vblank", {if1.mode, if1.vblank_irq}, {2'd0, 1'b0});
      if (c == 65664) chk("vblank_entry", {if1.mode, if1.ly, if1.dot, if1.vblank_irq}, {2'd1, 8'd144, 9'd0, 1'b1});
      if (c == 65665) chk("vblank_one_cycle", {if1.mode, if1.vblank_irq}, {2'd1, 1'b0});
      if (c == 70223) chk("frame_last", {if1.mode, if1.ly, if1.dot}, {2'd1, 8'd153, 9'd455});
      if1.mode3_done = (c == 252 || c == 952 || c == 1768);
      if (c == 2290) if1.stat_sel = 4'b1001;
      if (c == 2736) if1.stat_sel = 4'b0000;
      tick;
    end
    chk("ly_wrap", {if1.ly, if1.dot, if1.mode}, {8'd0, 9'd0, 2'd2});
    chk("frame2_start", {if1.frame_start, if1.mode2_start}, 2'b11);
    chk("vblank_count", vb_cnt, 1);
    chk("frame_start_count", fs_cnt, 1);
    chk("pos_mismatches", bad_pos, 0);
    chk("strobe_mismatches", bad_str, 0);
    chk("stat_mismatches", bad_stat, 0);
    chk("timeout_mismatches", bad_to, 0);
    repeat (150) tick;
    chk("pre_rst_xfer", {if1.mode, if1.dot}, {2'd3, 9'd150});
    rst = 1'b1; if1.mode3_done = 1'b1;
    tick;
    chk("midrst_pos", {if1.mode, if1.ly, if1.dot}, 0);
    chk("midrst_strobes", {if1.mode2_start, if1.mode3_start, if1.frame_start, if1.vblank_irq, if1.stat_irq}, 0);
    chk("midrst_timeout", if1.mode3_timeout, 0);
    rst = 1'b0; if1.mode3_done = 1'b0;
    tick;
    chk("post_rst", {if1.mode, if1.ly, if1.dot, if1.mode2_start, if1.frame_start}, {2'd2, 8'd0, 9'd0, 1'b1, 1'b1});
    chk("u2_off", {if2.mode, if2.ly, if2.dot, if2.frame_start}, 0);
    if2.lcd_en = 1'b1;
    tick;
    chk("u2_on", {if2.mode, if2.frame_start, if2.mode2_start}, {2'd2, 1'b1, 1'b1});
    repeat (13400) tick;
    chk("u2_pre_drop", {if2.ly, if2.dot, if2.mode, if2.mode3_timeout}, {8'd60, 9'd200, 2'd0, 1'b1});
    if2.lcd_en = 1'b0;
    tick;
    chk("u2_drop", {if2.mode, if2.ly, if2.dot, if2.mode3_timeout}, 0);
    chk("u2_drop_strobes", {if2.mode2_start, if2.frame_start, if2.vblank_irq, if2.stat_irq}, 0);
    tick;
    chk("u2_off_hold", {if2.ly, if2.dot}, 0);
    if2.lcd_en = 1'b1;
    tick;
    chk("u2_restore", {if2.mode, if2.ly, if2.dot, if2.frame_start, if2.mode2_start}, {2'd2, 8'd0, 9'd0, 1'b1, 1'b1});
    tick;
    chk("u2_run", {if2.dot, if2.frame_start, if2.mode2_start}, {9'd1, 1'b0, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
